// File: rtl/ccc_reconfig_ctrl.sv
// CCC divider reconfiguration controller: accepts a divider request, blanks the
// downstream clock, loads new codes and re-qualifies PLL lock before release.
module ccc_reconfig_ctrl #(
  parameter int         LOCK_TIMEOUT = 4096,
  parameter int         LOCK_STABLE  = 64,
  parameter int         SETTLE       = 16,
  parameter logic [6:0] RST_FINDIV   = 7'd2,
  parameter logic [6:0] RST_FBDIV    = 7'd19,
  parameter logic [4:0] RST_OADIV    = 5'd0,
  parameter logic [4:0] RST_OBDIV    = 5'd1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ,
  input  logic [6:0] REQ_FINDIV,
  input  logic [6:0] REQ_FBDIV,
  input  logic [4:0] REQ_OADIV,
  input  logic [4:0] REQ_OBDIV,
  input  logic       LOCK_IN,
  output logic       ACK,
  output logic [6:0] FINDIV,
  output logic [6:0] FBDIV,
  output logic [4:0] OADIV,
  output logic [4:0] OBDIV,
  output logic       CFG_STROBE,
  output logic       GATE_EN,
  output logic       LOCKED,
  output logic       BUSY,
  output logic       ERR,
  output logic       DONE
);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_GATE,
    ST_LOAD,
    ST_FAIL
  } state_t;

  localparam logic [12:0] TMO_LAST    = 13'(LOCK_TIMEOUT - 1);
  localparam logic [12:0] STABLE_LAST = 13'(LOCK_STABLE - 1);
  localparam logic [12:0] SETTLE_LAST = 13'(SETTLE - 1);

  state_t      state;
  logic [12:0] cnt;
  logic        lock_m;
  logic        lock_s;
  logic [6:0]  lat_findiv;
  logic [6:0]  lat_fbdiv;
  logic [4:0]  lat_oadiv;
  logic [4:0]  lat_obdiv;
  logic        accept;

  function automatic logic [12:0] sat_inc(input logic [12:0] v);
    return (v == '1) ? v : v + 13'd1;
  endfunction

  // Lock loss in RUN outranks a simultaneous request.
  assign accept = REQ && (((state == ST_RUN) && lock_s) || (state == ST_FAIL));

  always_ff @(posedge CLK) begin
    if (accept) begin
      lat_findiv <= REQ_FINDIV;
      lat_fbdiv  <= REQ_FBDIV;
      lat_oadiv  <= REQ_OADIV;
      lat_obdiv  <= REQ_OBDIV;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= ST_WAIT_LOCK;
      cnt        <= '0;
      lock_m     <= 1'b0;
      lock_s     <= 1'b0;
      FINDIV     <= RST_FINDIV;
      FBDIV      <= RST_FBDIV;
      OADIV      <= RST_OADIV;
      OBDIV      <= RST_OBDIV;
      ACK        <= 1'b0;
      CFG_STROBE <= 1'b0;
      DONE       <= 1'b0;
      GATE_EN    <= 1'b0;
      LOCKED     <= 1'b0;
      ERR        <= 1'b0;
      BUSY       <= 1'b1;
    end else begin
      lock_m     <= LOCK_IN;
      lock_s     <= lock_m;
      ACK        <= 1'b0;
      CFG_STROBE <= 1'b0;
      DONE       <= 1'b0;
      if (accept) begin
        state   <= ST_GATE;
        cnt     <= '0;
        ACK     <= 1'b1;
        ERR     <= 1'b0;
        GATE_EN <= 1'b0;
        LOCKED  <= 1'b0;
        BUSY    <= 1'b1;
      end else begin
        case (state)
          ST_WAIT_LOCK: begin
            if (lock_s) begin
              state <= ST_STABLE;
              cnt   <= '0;
            end else if (cnt == TMO_LAST) begin
              state <= ST_FAIL;
              cnt   <= '0;
              ERR   <= 1'b1;
              BUSY  <= 1'b0;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
          ST_STABLE: begin
            if (!lock_s) begin
              state <= ST_WAIT_LOCK;
              cnt   <= '0;
            end else if (cnt == STABLE_LAST) begin
              state   <= ST_RUN;
              cnt     <= '0;
              GATE_EN <= 1'b1;
              LOCKED  <= 1'b1;
              DONE    <= 1'b1;
              BUSY    <= 1'b0;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
          ST_RUN: begin
            if (!lock_s) begin
              state   <= ST_WAIT_LOCK;
              cnt     <= '0;
              GATE_EN <= 1'b0;
              LOCKED  <= 1'b0;
              BUSY    <= 1'b1;
            end
          end
          ST_GATE: begin
            if (cnt == SETTLE_LAST) begin
              state      <= ST_LOAD;
              cnt        <= '0;
              FINDIV     <= lat_findiv;
              FBDIV      <= lat_fbdiv;
              OADIV      <= lat_oadiv;
              OBDIV      <= lat_obdiv;
              CFG_STROBE <= 1'b1;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
          ST_LOAD: begin
            // Lock is not trusted while the CCC relocks on the new codes.
            if (cnt == SETTLE_LAST) begin
              state <= ST_WAIT_LOCK;
              cnt   <= '0;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
          ST_FAIL: begin
            ERR <= 1'b1;
          end
          default: begin
            state <= ST_WAIT_LOCK;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/ccc_reconfig_ctrl.md
CCC_RECONFIG_CTRL -- requirements
Module: ccc_reconfig_ctrl

Interface
REQ-001 Parameter LOCK_TIMEOUT, 4096: max cycles to wait for synchronized lock.
REQ-002 Parameter LOCK_STABLE, 64: consecutive locked cycles required before release.
REQ-003 Parameter SETTLE, 16: cycles of gate-off blanking before and after a config load.
REQ-004 Parameters RST_FINDIV 7'd2, RST_FBDIV 7'd19, RST_OADIV 5'd0, RST_OBDIV 5'd1: power-on CCC divider codes.
REQ-005 One clock, CLK; reset RESET is asynchronous, active-high.
REQ-006 CLK  in  1  system clock (fabric clock).
REQ-007 RESET  in  1  async active-high reset.
REQ-008 REQ  in  1  reconfiguration request, level, held until ACK.
REQ-009 REQ_FINDIV / REQ_FBDIV  in  7 / 7  requested input / feedback divider codes.
REQ-010 REQ_OADIV / REQ_OBDIV  in  5 / 5  requested output A / B divider codes.
REQ-011 LOCK_IN  in  1  raw PLL lock, asynchronous to CLK.
REQ-012 ACK  out  1  one-cycle pulse: request accepted, fields latched.
REQ-013 FINDIV / FBDIV  out  7 / 7  divider codes driven to CCC.
REQ-014 OADIV / OBDIV  out  5 / 5  divider codes driven to CCC.
REQ-015 CFG_STROBE  out  1  one-cycle pulse when new codes are applied.
REQ-016 GATE_EN  out  1  downstream clock enable; high only while lock is qualified.
REQ-017 LOCKED / BUSY / ERR / DONE  out  1 each  qualified lock; sequence in progress; lock timeout (sticky); one-cycle completion pulse.

Function
REQ-018 LOCK_IN shall pass a 2-flop synchronizer (lock_s); all decisions use lock_s only.
REQ-019 States: WAIT_LOCK, STABLE, RUN, GATE, LOAD, FAIL; one shared 13-bit counter, cleared on every state entry.
REQ-020 WAIT_LOCK: lock_s=1 -> STABLE; counter reaching LOCK_TIMEOUT-1 with lock_s=0 -> FAIL.
REQ-021 STABLE: counts consecutive lock_s=1 cycles; lock_s=0 -> WAIT_LOCK; count reaching LOCK_STABLE-1 -> RUN.
REQ-022 Entering RUN: GATE_EN=1, LOCKED=1, DONE=1 for exactly that first RUN cycle.
REQ-023 RUN with lock_s=0: GATE_EN=0, LOCKED=0 next cycle, -> WAIT_LOCK, codes unchanged; lock loss takes priority over simultaneous REQ.
REQ-024 REQ sampled only in RUN or FAIL; acceptance asserts ACK one cycle, latches all four REQ_* fields, -> GATE; REQ in other states ignored, no ACK.
REQ-025 ERR clears on the ACK cycle; ERR sets on FAIL entry and holds while in FAIL.
REQ-026 GATE: GATE_EN=0, LOCKED=0 from the ACK cycle onward; after SETTLE cycles -> LOAD.
REQ-027 LOAD: first cycle drives latched codes onto FINDIV/FBDIV/OADIV/OBDIV with CFG_STROBE=1; lock_s ignored for SETTLE cycles, then -> WAIT_LOCK.
REQ-028 FAIL: GATE_EN=0, LOCKED=0, codes held; exit only by accepted REQ.
REQ-029 BUSY=1 in WAIT_LOCK, STABLE, GATE, LOAD; BUSY=0 in RUN, FAIL.
REQ-030 Divider codes pass through unmodified; no range checking; counters saturate, never wrap.

Reset
REQ-031 RESET asserted: state WAIT_LOCK, counter 0, synchronizer 0, codes = RST_* values, ACK/CFG_STROBE/DONE/GATE_EN/LOCKED/ERR=0, BUSY=1.
REQ-032 RESET mid-sequence shall abandon any latched request; no ACK or DONE emitted for it.

Verification
REQ-033 Reset, LOCK_IN=1 from cycle 0 -> DONE pulse, GATE_EN=1 within 2+LOCK_STABLE+1 cycles; codes 2/19/0/1.
REQ-034 In RUN, REQ with codes 1/39/1/3 -> ACK 1 cycle, GATE_EN=0, CFG_STROBE exactly SETTLE cycles after ACK with outputs 1/39/1/3; LOCK_IN held 1 -> DONE after SETTLE+LOCK_STABLE further cycles.
REQ-035 LOCK_IN=0 permanently after reset -> ERR=1, BUSY=0 after LOCK_TIMEOUT+2 cycles; then REQ -> ACK, ERR=0 same cycle.
REQ-036 LOCK_IN toggles 1 for 10 cycles, 0 for 1 cycle repeatedly (LOCK_STABLE=64) -> GATE_EN never asserts, no DONE.
REQ-037 RUN, REQ and LOCK_IN fall same cycle -> no ACK, state WAIT_LOCK; REQ still held is accepted once RUN re-entered.
REQ-038 RESET asserted during LOAD -> codes revert to 2/19/0/1 immediately, no DONE for abandoned request.
